// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS main controller:
// opcodes, state codes, mux selects and the decoded control word.
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM4 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    FETCH1  = 4'd0,
    FETCH2  = 4'd1,
    FETCH3  = 4'd2,
    FETCH4  = 4'd3,
    DECODE  = 4'd4,
    MEMADR  = 4'd5,
    LBRD    = 4'd6,
    LBWR    = 4'd7,
    SBWR    = 4'd8,
    RTYPEEX = 4'd9,
    RTYPEWR = 4'd10,
    BEQEX   = 4'd11,
    JEX     = 4'd12,
    ADDIWR  = 4'd13
  } state_t;

  typedef struct packed {
    logic       memread;
    logic       memwrite;
    logic       alusrca;
    logic       memtoreg;
    logic       iord;
    logic       pcwrite;
    logic       branch;
    logic       regwrite;
    logic       regdst;
    logic [1:0] pcsource;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [3:0] irwrite;
  } ctrl_t;

  function automatic logic op_known(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_J) ||
           (op == OP_BEQ) || (op == OP_ADDI) ||
           (op == OP_LB) || (op == OP_SB);
  endfunction

endpackage

// File: rtl/mc_if.sv
// Controller <-> datapath bundle: opcode/zero in, control strobes out.
// master = controller side, slave = datapath side.
interface mc_if;
  logic [5:0] op;
  logic       zero;
  logic       memread;
  logic       memwrite;
  logic       alusrca;
  logic       memtoreg;
  logic       iord;
  logic       pcen;
  logic       regwrite;
  logic       regdst;
  logic [1:0] pcsource;
  logic [1:0] alusrcb;
  logic [1:0] aluop;
  logic [3:0] irwrite;
  logic       illegal_op;
  logic [3:0] state_dbg;

  modport master (
    input  op, zero,
    output memread, memwrite, alusrca, memtoreg, iord, pcen,
    output regwrite, regdst, pcsource, alusrcb, aluop, irwrite,
    output illegal_op, state_dbg
  );

  modport slave (
    output op, zero,
    input  memread, memwrite, alusrca, memtoreg, iord, pcen,
    input  regwrite, regdst, pcsource, alusrcb, aluop, irwrite,
    input  illegal_op, state_dbg
  );
endinterface

// File: rtl/mc_ctrl_outdec.sv
// Pure state -> control word decode (Moore part of the controller).
// Ports: state in, ctrl (decoded control word) out.
module mc_ctrl_outdec
  import mc_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      FETCH1, FETCH2, FETCH3, FETCH4: begin
        ctrl.memread  = 1'b1;
        ctrl.alusrcb  = SRCB_ONE;
        ctrl.pcwrite  = 1'b1;
        ctrl.pcsource = PCSRC_ALU;
        ctrl.irwrite  = 4'b0001 << state[1:0];
      end
      DECODE: ctrl.alusrcb = SRCB_IMM4;
      MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
      end
      LBRD: begin
        ctrl.memread = 1'b1;
        ctrl.iord    = 1'b1;
      end
      LBWR: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = 1'b1;
      end
      SBWR: begin
        ctrl.memwrite = 1'b1;
        ctrl.iord     = 1'b1;
      end
      RTYPEEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      RTYPEWR: begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      BEQEX: begin
        ctrl.alusrca  = 1'b1;
        ctrl.aluop    = ALUOP_SUB;
        ctrl.branch   = 1'b1;
        ctrl.pcsource = PCSRC_ALUOUT;
      end
      JEX: begin
        ctrl.pcwrite  = 1'b1;
        ctrl.pcsource = PCSRC_JUMP;
      end
      ADDIWR: ctrl.regwrite = 1'b1;
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS main control FSM: 4-byte fetch, decode, execute/mem/wb.
// Ports: clk, reset_n (async, active-low), bus (mc_if.master).
module mc_controller
  import mc_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  mc_if.master bus
);

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= FETCH1;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = FETCH1;
    case (state_q)
      FETCH1:  state_d = FETCH2;
      FETCH2:  state_d = FETCH3;
      FETCH3:  state_d = FETCH4;
      FETCH4:  state_d = DECODE;
      DECODE: begin
        case (bus.op)
          OP_LB, OP_SB, OP_ADDI: state_d = MEMADR;
          OP_RTYPE:              state_d = RTYPEEX;
          OP_BEQ:                state_d = BEQEX;
          OP_J:                  state_d = JEX;
          default:               state_d = FETCH1;
        endcase
      end
      MEMADR: begin
        case (bus.op)
          OP_LB:   state_d = LBRD;
          OP_SB:   state_d = SBWR;
          OP_ADDI: state_d = ADDIWR;
          default: state_d = FETCH1;
        endcase
      end
      LBRD:    state_d = LBWR;
      RTYPEEX: state_d = RTYPEWR;
      default: state_d = FETCH1;
    endcase
  end

  mc_ctrl_outdec u_outdec (
    .state (state_q),
    .ctrl  (ctrl)
  );

  assign bus.memread    = ctrl.memread;
  assign bus.memwrite   = ctrl.memwrite;
  assign bus.alusrca    = ctrl.alusrca;
  assign bus.memtoreg   = ctrl.memtoreg;
  assign bus.iord       = ctrl.iord;
  assign bus.regwrite   = ctrl.regwrite;
  assign bus.regdst     = ctrl.regdst;
  assign bus.pcsource   = ctrl.pcsource;
  assign bus.alusrcb    = ctrl.alusrcb;
  assign bus.aluop      = ctrl.aluop;
  assign bus.irwrite    = ctrl.irwrite;
  // branch only moves the PC when the compare came out equal
  assign bus.pcen       = ctrl.pcwrite | (ctrl.branch & bus.zero);
  assign bus.illegal_op = (state_q == DECODE) && !op_known(bus.op);
  assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: per-cycle vector table plus
// a hand-written mid-instruction reset sequence.
module tb_mc_controller;

  logic clk;
  logic reset_n;
  int   tests;
  int   fails;

  mc_if bus ();

  mc_controller dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cw order: memread memwrite alusrca memtoreg iord pcen regwrite regdst
  //           _pcsource_alusrcb_aluop_irwrite_illegal
  typedef struct {
    logic [5:0]  op;
    logic        zero;
    logic [3:0]  st;
    logic [18:0] cw;
  } vec_t;

  vec_t vecs[$];

  localparam logic [18:0] CW_DEC = 19'b00000000_00_11_00_0000_0;

  function automatic logic [18:0] dut_cw();
    return {bus.memread, bus.memwrite, bus.alusrca, bus.memtoreg,
            bus.iord, bus.pcen, bus.regwrite, bus.regdst,
            bus.pcsource, bus.alusrcb, bus.aluop, bus.irwrite,
            bus.illegal_op};
  endfunction

  task automatic add(input logic [5:0] op, input logic zero,
                     input logic [3:0] st, input logic [18:0] cw);
    vec_t v;
    v.op = op; v.zero = zero; v.st = st; v.cw = cw;
    vecs.push_back(v);
  endtask

  task automatic add_fetch(input logic [5:0] op);
    add(op, 1'b0, 4'd0, 19'b10000100_00_01_00_0001_0);
    add(op, 1'b1, 4'd1, 19'b10000100_00_01_00_0010_0);
    add(op, 1'b0, 4'd2, 19'b10000100_00_01_00_0100_0);
    add(op, 1'b1, 4'd3, 19'b10000100_00_01_00_1000_0);
  endtask

  task automatic chk(input string name, input logic [18:0] act,
                     input logic [18:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset_n = 1'b0;
    bus.op = 6'b000000;
    bus.zero = 1'b0;

    // lb
    add_fetch(6'b100000);
    add(6'b100000, 1'b0, 4'd4, CW_DEC);
    add(6'b100000, 1'b0, 4'd5, 19'b00100000_00_10_00_0000_0);
    add(6'b100000, 1'b0, 4'd6, 19'b10001000_00_00_00_0000_0);
    add(6'b100000, 1'b0, 4'd7, 19'b00010010_00_00_00_0000_0);
    // sb
    add_fetch(6'b101000);
    add(6'b101000, 1'b0, 4'd4, CW_DEC);
    add(6'b101000, 1'b0, 4'd5, 19'b00100000_00_10_00_0000_0);
    add(6'b101000, 1'b0, 4'd8, 19'b01001000_00_00_00_0000_0);
    // R-type
    add_fetch(6'b000000);
    add(6'b000000, 1'b0, 4'd4, CW_DEC);
    add(6'b000000, 1'b0, 4'd9, 19'b00100000_00_00_10_0000_0);
    add(6'b000000, 1'b0, 4'd10, 19'b00000011_00_00_00_0000_0);
    // beq taken; zero high in DECODE must not load PC
    add_fetch(6'b000100);
    add(6'b000100, 1'b1, 4'd4, CW_DEC);
    add(6'b000100, 1'b1, 4'd11, 19'b00100100_01_00_01_0000_0);
    // beq not taken
    add_fetch(6'b000100);
    add(6'b000100, 1'b0, 4'd4, CW_DEC);
    add(6'b000100, 1'b0, 4'd11, 19'b00100000_01_00_01_0000_0);
    // j
    add_fetch(6'b000010);
    add(6'b000010, 1'b0, 4'd4, CW_DEC);
    add(6'b000010, 1'b0, 4'd12, 19'b00000100_10_00_00_0000_0);
    // addi
    add_fetch(6'b001000);
    add(6'b001000, 1'b0, 4'd4, CW_DEC);
    add(6'b001000, 1'b0, 4'd5, 19'b00100000_00_10_00_0000_0);
    add(6'b001000, 1'b0, 4'd13, 19'b00000010_00_00_00_0000_0);
    // illegal opcode: one-cycle pulse then refetch
    add_fetch(6'b111111);
    add(6'b111111, 1'b0, 4'd4, 19'b00000000_00_11_00_0000_1);
    add(6'b111111, 1'b0, 4'd0, 19'b10000100_00_01_00_0001_0);

    // reset state, checked while reset is held
    #12;
    chk("reset_state", {15'd0, bus.state_dbg}, 19'd0);
    chk("reset_cw", dut_cw(), 19'b10000100_00_01_00_0001_0);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      if (i != 0) @(negedge clk);
      bus.op = vecs[i].op;
      bus.zero = vecs[i].zero;
      #1;
      chk($sformatf("vec%0d_state", i), {15'd0, bus.state_dbg},
          {15'd0, vecs[i].st});
      chk($sformatf("vec%0d_cw", i), dut_cw(), vecs[i].cw);
    end

    // reset asserted in the middle of RTYPEEX
    bus.op = 6'b000000;
    bus.zero = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    chk("pre_reset_rtypeex", {15'd0, bus.state_dbg}, 19'd9);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midreset_state", {15'd0, bus.state_dbg}, 19'd0);
    chk("midreset_cw", dut_cw(), 19'b10000100_00_01_00_0001_0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rel_c1", {15'd0, bus.irwrite}, 19'b0001);
    @(negedge clk); #1;
    chk("rel_c2", {15'd0, bus.irwrite}, 19'b0010);
    @(negedge clk); #1;
    chk("rel_c3", {15'd0, bus.irwrite}, 19'b0100);
    @(negedge clk); #1;
    chk("rel_c4", {15'd0, bus.irwrite}, 19'b1000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
